// File: rtl/env_int_ctl_pkg.sv
// Shared definitions for the environment interrupt controller:
// register offsets, CTRL bit positions, FSM states and the priority encoder.
package env_int_ctl_pkg;

  // Register offsets within the 8-port I/O window
  localparam logic [2:0] REG_CTRL = 3'd0;
  localparam logic [2:0] REG_MASK = 3'd1;
  localparam logic [2:0] REG_PEND = 3'd2;
  localparam logic [2:0] REG_STAT = 3'd3;
  localparam logic [2:0] REG_CNT0 = 3'd4;

  // CTRL bit positions
  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_CLR_BIT = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_ACK    = 2'd2,
    ST_SVC    = 2'd3
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } cand_t;

  // Lowest-index set bit wins
  function automatic cand_t prio_enc(input logic [3:0] req);
    cand_t c;
    c.valid = |req;
    c.idx   = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (req[i]) c.idx = 2'(i);
    end
    return c;
  endfunction

endpackage

// File: rtl/env_int_timer.sv
// Per-source 8-bit countdown timer. Loading a non-zero value starts it,
// loading zero stops it; when it counts through 1 it emits a one-cycle fire.
module env_int_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       fire
);

  logic [7:0] cnt;

  // A reload in the same cycle as expiry restarts the count instead of firing
  assign fire = (cnt == 8'd1) && !load;

  // Count register: load has priority, otherwise decrement toward zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 8'd0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != 8'd0) begin
      cnt <= cnt - 8'd1;
    end
  end

endmodule

// File: rtl/env_int_ctl.sv
// Environment interrupt controller: I/O register window on the tv80 bus,
// timer and edge-triggered sources, Z80 mode-2 vectored acknowledge.
module env_int_ctl
  import env_int_ctl_pkg::*;
#(
  parameter int         NUM_SRC   = 4,
  parameter logic [7:0] BASE_ADDR = 8'h90,
  parameter logic [7:0] VEC_BASE  = 8'hE0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               iorq_n,
  input  logic               rd_n,
  input  logic               wr_n,
  input  logic               m1_n,
  input  logic [7:0]         addr,
  input  logic [7:0]         DO,
  inout  wire  [7:0]         DI,
  input  logic [NUM_SRC-1:0] ext_irq,
  output logic               int_n,
  output logic               in_svc
);

  logic [7:0]         off;
  logic [2:0]         reg_off;
  logic               in_win;
  logic               wr_acc;
  logic               rd_sel;
  logic               ack_cyc;
  logic               wr_seen;
  logic               ctrl_en;
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] pend;
  logic [NUM_SRC-1:0] pend_nxt;
  logic [NUM_SRC-1:0] pend_clr;
  logic [NUM_SRC-1:0] pend_set;
  logic [NUM_SRC-1:0] ext_q;
  logic [NUM_SRC-1:0] fire;
  logic [3:0]         req;
  cand_t              cand;
  logic               cand_valid;
  logic [1:0]         svc_idx;
  state_t             state, state_nxt;
  logic               take_ack;
  logic               eoi;
  logic               vec_drv;
  logic [7:0]         rd_data;

  // Address decode and bus cycle qualification
  assign off      = addr - BASE_ADDR;
  assign in_win   = (off < 8'd8);
  assign reg_off  = off[2:0];
  assign wr_acc   = !iorq_n && !wr_n && m1_n && in_win && !wr_seen;
  assign rd_sel   = !iorq_n && !rd_n && m1_n && in_win;
  assign ack_cyc  = !iorq_n && !m1_n;
  assign eoi      = wr_acc && (reg_off == REG_STAT);

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_tmr
    env_int_timer u_tmr (
      .clk      (clk),
      .rst      (reset),
      .load     (wr_acc && (reg_off == (REG_CNT0 + 3'(i)))),
      .load_val (DO),
      .fire     (fire[i])
    );
  end

  // Pad the request vector to the encoder width
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    req              = 4'd0;
    req[NUM_SRC-1:0] = pend & mask;
  end

  assign cand       = prio_enc(req);
  assign cand_valid = cand.valid && ctrl_en;
  assign take_ack   = (state == ST_ASSERT) && cand_valid && ack_cyc;

  // Pending next value: sets from timers/edges override every clear source
  always_comb begin
    pend_set = fire | (ext_irq & ~ext_q);
    pend_clr = '0;
    if (wr_acc && (reg_off == REG_PEND)) pend_clr = DO[NUM_SRC-1:0];
    if (wr_acc && (reg_off == REG_CTRL) && DO[CTRL_CLR_BIT]) pend_clr = '1;
    if (take_ack) pend_clr[cand.idx] = 1'b1;
    pend_nxt = (pend & ~pend_clr) | pend_set;
  end

  // One write per iorq_n low period
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (reset)       wr_seen <= 1'b0;
    else if (iorq_n) wr_seen <= 1'b0;
    else if (wr_acc) wr_seen <= 1'b1;
  end

  // Programmable registers, pending bits and edge detector
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_en <= 1'b0;
      mask    <= '0;
      pend    <= '0;
      ext_q   <= '0;
      svc_idx <= 2'd0;
    end else begin
      ext_q <= ext_irq;
      pend  <= pend_nxt;
      if (wr_acc && (reg_off == REG_CTRL)) ctrl_en <= DO[CTRL_EN_BIT];
      if (wr_acc && (reg_off == REG_MASK)) mask    <= DO[NUM_SRC-1:0];
      if (take_ack)                        svc_idx <= cand.idx;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (cand_valid) state_nxt = ST_ASSERT;
      ST_ASSERT: begin
        if (!cand_valid)  state_nxt = ST_IDLE;
        else if (ack_cyc) state_nxt = ST_ACK;
      end
      ST_ACK:    if (iorq_n) state_nxt = ST_SVC;
      ST_SVC:    if (eoi)    state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  assign int_n  = (state != ST_ASSERT);
  assign in_svc = (state == ST_SVC);

  // Register read mux
  always_comb begin
    rd_data = 8'h00;
    case (reg_off)
      REG_CTRL: rd_data[CTRL_EN_BIT] = ctrl_en;
      REG_MASK: rd_data[NUM_SRC-1:0] = mask;
      REG_PEND: rd_data[NUM_SRC-1:0] = pend;
      REG_STAT: rd_data = {in_svc, 5'b0, svc_idx};
      default:  rd_data = 8'h00;
    endcase
  end

  // Vector and register reads are mutually exclusive through m1_n
  assign vec_drv = (state == ST_ACK) && ack_cyc;
  assign DI = vec_drv ? (VEC_BASE | {5'b0, svc_idx, 1'b0}) :
              rd_sel  ? rd_data : 8'bz;

endmodule

// File: tb/tb_env_int_ctl.sv
// Directed self-checking bench for env_int_ctl.
module tb_env_int_ctl;

  logic       clk = 1'b0;
  logic       reset;
  logic       iorq_n, rd_n, wr_n, m1_n;
  logic [7:0] addr, dout;
  logic [3:0] ext_irq;
  wire  [7:0] di;
  logic       int_n, in_svc;
  logic       tb_drv;
  logic [7:0] tb_val;
  int         passed = 0;
  int         total  = 0;
  logic [7:0] rv;

  localparam logic [7:0] A_CTRL = 8'h90;
  localparam logic [7:0] A_MASK = 8'h91;
  localparam logic [7:0] A_PEND = 8'h92;
  localparam logic [7:0] A_STAT = 8'h93;
  localparam logic [7:0] A_CNT0 = 8'h94;
  localparam logic [7:0] A_CNT1 = 8'h95;
  localparam logic [7:0] A_CNT2 = 8'h96;

  assign di = tb_drv ? tb_val : 8'bz;

  always #5 clk = ~clk;

  env_int_ctl dut (
    .clk     (clk),
    .reset   (reset),
    .iorq_n  (iorq_n),
    .rd_n    (rd_n),
    .wr_n    (wr_n),
    .m1_n    (m1_n),
    .addr    (addr),
    .DO      (dout),
    .DI      (di),
    .ext_irq (ext_irq),
    .int_n   (int_n),
    .in_svc  (in_svc)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Write held for two clock edges; only the first may be accepted
  task automatic io_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; dout = d; iorq_n = 1'b0; wr_n = 1'b0;
    repeat (2) @(negedge clk);
    iorq_n = 1'b1; wr_n = 1'b1;
  endtask

  task automatic io_read(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk);
    addr = a; iorq_n = 1'b0; rd_n = 1'b0;
    #1 d = di;
    #1 iorq_n = 1'b1; rd_n = 1'b1;
  endtask

  task automatic read_check(input string tag, input logic [7:0] a, input logic [7:0] exp);
    logic [7:0] d;
    io_read(a, d);
    check(tag, d, exp);
  endtask

  // The DUT is floating iff two opposing bench values read back unchanged
  task automatic float_check(input string tag);
    logic [7:0] a, b;
    tb_val = 8'h5A; tb_drv = 1'b1;
    #1 a = di;
    tb_val = 8'hA5;
    #1 b = di;
    tb_drv = 1'b0;
    total++;
    assert ({a, b} === 16'h5AA5) passed++;
    else $error("FAIL %s: observed %h expected 5aa5", tag, {a, b});
  endtask

  task automatic ack(input string tag, input logic [7:0] exp_vec);
    @(negedge clk);
    m1_n = 1'b0; iorq_n = 1'b0;
    @(negedge clk);
    check({tag, "_vec"}, di, exp_vec);
    check({tag, "_intn"}, 8'(int_n), 8'h01);
    m1_n = 1'b1; iorq_n = 1'b1;
    @(negedge clk);
    check({tag, "_svc"}, 8'(in_svc), 8'h01);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1;
    addr = 8'h00; dout = 8'h00; ext_irq = 4'h0; tb_drv = 1'b0; tb_val = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("rst_intn", 8'(int_n), 8'h01);
    check("rst_svc", 8'(in_svc), 8'h00);
    float_check("rst_float");
    read_check("rst_ctrl", A_CTRL, 8'h00);
    read_check("rst_mask", A_MASK, 8'h00);
    read_check("rst_pend", A_PEND, 8'h00);
    read_check("rst_stat", A_STAT, 8'h00);
    read_check("cnt_reads0", A_CNT0, 8'h00);

    // 1: timer 0 fires 5 clocks after accept, int_n one clock later
    io_write(A_MASK, 8'h01);
    io_write(A_CTRL, 8'h01);
    read_check("t1_ctrl", A_CTRL, 8'h01);
    io_write(A_CNT0, 8'h05);
    repeat (4) @(negedge clk);
    check("t1_intn_hi", 8'(int_n), 8'h01);
    @(negedge clk);
    check("t1_intn_lo", 8'(int_n), 8'h00);
    ack("t1_ack", 8'hE0);
    read_check("t1_stat", A_STAT, 8'h80);
    read_check("t1_pend", A_PEND, 8'h00);
    io_write(A_STAT, 8'h00);
    check("t1_eoi", 8'(in_svc), 8'h00);

    // 2: two pending sources served in priority order
    io_write(A_CTRL, 8'h00);
    io_write(A_MASK, 8'h05);
    io_write(A_CNT0, 8'h01);
    io_write(A_CNT2, 8'h01);
    read_check("t2_pend", A_PEND, 8'h05);
    check("t2_dis_intn", 8'(int_n), 8'h01);
    io_write(A_CTRL, 8'h01);
    check("t2_intn_a", 8'(int_n), 8'h00);
    ack("t2_ack0", 8'hE0);
    read_check("t2_pend2", A_PEND, 8'h04);
    check("t2_nonest", 8'(int_n), 8'h01);
    io_write(A_STAT, 8'h00);
    @(negedge clk);
    check("t2_intn_b", 8'(int_n), 8'h00);
    ack("t2_ack2", 8'hE4);
    read_check("t2_stat", A_STAT, 8'h82);
    io_write(A_STAT, 8'h00);

    // 3: edge request during service stays pending until EOI
    io_write(A_MASK, 8'h03);
    io_write(A_CNT0, 8'h01);
    repeat (2) @(negedge clk);
    check("t3_intn_a", 8'(int_n), 8'h00);
    ack("t3_ack0", 8'hE0);
    ext_irq = 4'h2;
    repeat (3) @(negedge clk);
    read_check("t3_pend", A_PEND, 8'h02);
    check("t3_hold", 8'(int_n), 8'h01);
    io_write(A_STAT, 8'h00);
    check("t3_intn_b", 8'(int_n), 8'h00);
    ack("t3_ack1", 8'hE2);
    io_write(A_STAT, 8'h00);
    ext_irq = 4'h0;

    // 4: masking during ASSERT withdraws the request; a late ack floats DI
    io_write(A_MASK, 8'h01);
    io_write(A_CNT0, 8'h01);
    repeat (2) @(negedge clk);
    check("t4_intn_a", 8'(int_n), 8'h00);
    @(negedge clk);
    addr = A_MASK; dout = 8'h00; iorq_n = 1'b0; wr_n = 1'b0;
    @(negedge clk);
    check("t4_intn_1clk", 8'(int_n), 8'h00);
    @(negedge clk);
    check("t4_intn_2clk", 8'(int_n), 8'h01);
    iorq_n = 1'b1; wr_n = 1'b1;
    @(negedge clk);
    m1_n = 1'b0; iorq_n = 1'b0;
    @(negedge clk);
    float_check("t4_float");
    m1_n = 1'b1; iorq_n = 1'b1;
    @(negedge clk);
    check("t4_nosvc", 8'(in_svc), 8'h00);
    read_check("t4_pend", A_PEND, 8'h01);
    io_write(A_CTRL, 8'h03);
    read_check("t4_clr", A_PEND, 8'h00);
    read_check("t4_ctrl", A_CTRL, 8'h01);

    // 5: timer set and W1C clear in the same cycle -> set wins
    io_write(A_CNT1, 8'h01);
    repeat (2) @(negedge clk);
    read_check("t5_pend_a", A_PEND, 8'h02);
    io_write(A_CNT1, 8'h03);
    io_write(A_PEND, 8'h02);
    read_check("t5_setwins", A_PEND, 8'h02);
    io_write(A_PEND, 8'h02);
    read_check("t5_w1c", A_PEND, 8'h00);

    // 6: reset during ACK
    io_write(A_MASK, 8'h01);
    io_write(A_CNT0, 8'h01);
    repeat (2) @(negedge clk);
    check("t6_intn", 8'(int_n), 8'h00);
    @(negedge clk);
    m1_n = 1'b0; iorq_n = 1'b0;
    @(negedge clk);
    check("t6_vec", di, 8'hE0);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_intn", 8'(int_n), 8'h01);
    check("t6_rst_svc", 8'(in_svc), 8'h00);
    float_check("t6_float");
    @(negedge clk);
    m1_n = 1'b1; iorq_n = 1'b1;
    reset = 1'b0;
    read_check("t6_ctrl", A_CTRL, 8'h00);
    read_check("t6_mask", A_MASK, 8'h00);
    read_check("t6_pend", A_PEND, 8'h00);
    read_check("t6_stat", A_STAT, 8'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
